// File: rtl/pcpi_dispatch_if.sv
// PCPI bundles: the CPU-facing port and the broadcast port toward the coprocessors.
// master drives the request side, slave answers it.

interface pcpi_up_if;
    logic        up_valid;
    logic [31:0] up_insn;
    logic [31:0] up_rs1;
    logic [31:0] up_rs2;
    logic [31:0] up_rs3;
    logic        up_wr;
    logic [31:0] up_rd;
    logic        up_wait;
    logic        up_ready;

    modport master (
        output up_valid, up_insn, up_rs1, up_rs2, up_rs3,
        input  up_wr, up_rd, up_wait, up_ready
    );
    modport slave (
        input  up_valid, up_insn, up_rs1, up_rs2, up_rs3,
        output up_wr, up_rd, up_wait, up_ready
    );
endinterface

interface pcpi_dn_if #(
    parameter int NUM_COPROC = 2
);
    logic [NUM_COPROC-1:0]    dn_valid;
    logic [31:0]              dn_insn;
    logic [31:0]              dn_rs1;
    logic [31:0]              dn_rs2;
    logic [31:0]              dn_rs3;
    logic [NUM_COPROC-1:0]    dn_wr;
    logic [32*NUM_COPROC-1:0] dn_rd;
    logic [NUM_COPROC-1:0]    dn_wait;
    logic [NUM_COPROC-1:0]    dn_ready;

    modport master (
        output dn_valid, dn_insn, dn_rs1, dn_rs2, dn_rs3,
        input  dn_wr, dn_rd, dn_wait, dn_ready
    );
    modport slave (
        input  dn_valid, dn_insn, dn_rs1, dn_rs2, dn_rs3,
        output dn_wr, dn_rd, dn_wait, dn_ready
    );
endinterface

// File: rtl/pcpi_dispatch.sv
// Shares one PicoRV32 PCPI port among several coprocessors: broadcast, first claimer owns,
// result forwarded to the CPU, with probe and busy watchdogs.
//
// state | meaning
// IDLE  | no request in flight, waiting for up_valid
// PROBE | request broadcast to all slaves, waiting for a claim
// BUSY  | one owner holds the CPU with wait, only its signals are sampled
// DONE  | up_ready pulse with the latched result
// DRAIN | outputs quiet until the CPU drops up_valid

module pcpi_dispatch #(
    parameter int  NUM_COPROC   = 2,
    parameter int  PROBE_CYCLES = 8,
    parameter int  BUSY_TIMEOUT = 1024,
    localparam int OWNER_W      = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    pcpi_up_if.slave           up,
    pcpi_dn_if.master          dn,
    output logic [OWNER_W-1:0] owner,
    output logic               err_timeout,
    output logic               err_multi
);

    localparam int CNT_MAX = (PROBE_CYCLES > BUSY_TIMEOUT) ? PROBE_CYCLES : BUSY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_BUSY,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_COPROC-1:0]   dn_valid_q, dn_valid_d;
    logic [31:0]             dn_insn_q, dn_insn_d;
    logic [31:0]             dn_rs1_q, dn_rs1_d;
    logic [31:0]             dn_rs2_q, dn_rs2_d;
    logic [31:0]             dn_rs3_q, dn_rs3_d;
    logic                    up_wr_q, up_wr_d;
    logic [31:0]             up_rd_q, up_rd_d;
    logic                    up_wait_q, up_wait_d;
    logic                    up_ready_q, up_ready_d;
    logic [OWNER_W-1:0]      owner_q, owner_d;
    logic                    err_timeout_q, err_timeout_d;
    logic                    err_multi_q, err_multi_d;

    logic [NUM_COPROC-1:0]   claim;
    logic [OWNER_W-1:0]      ready_idx;
    logic [OWNER_W-1:0]      claim_idx;
    logic [CNT_W-1:0]        cnt_inc;

    function automatic logic [OWNER_W-1:0] lowest_set(input logic [NUM_COPROC-1:0] v);
        logic [OWNER_W-1:0] idx;
        idx = '0;
        for (int i = NUM_COPROC - 1; i >= 0; i--) begin
            if (v[i]) idx = OWNER_W'(i);
        end
        return idx;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            dn_valid_q    <= '0;
            dn_insn_q     <= '0;
            dn_rs1_q      <= '0;
            dn_rs2_q      <= '0;
            dn_rs3_q      <= '0;
            up_wr_q       <= 1'b0;
            up_rd_q       <= '0;
            up_wait_q     <= 1'b0;
            up_ready_q    <= 1'b0;
            owner_q       <= '0;
            err_timeout_q <= 1'b0;
            err_multi_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dn_valid_q    <= dn_valid_d;
            dn_insn_q     <= dn_insn_d;
            dn_rs1_q      <= dn_rs1_d;
            dn_rs2_q      <= dn_rs2_d;
            dn_rs3_q      <= dn_rs3_d;
            up_wr_q       <= up_wr_d;
            up_rd_q       <= up_rd_d;
            up_wait_q     <= up_wait_d;
            up_ready_q    <= up_ready_d;
            owner_q       <= owner_d;
            err_timeout_q <= err_timeout_d;
            err_multi_q   <= err_multi_d;
        end
    end

    always_comb begin
        claim     = dn.dn_wait | dn.dn_ready;
        ready_idx = lowest_set(dn.dn_ready);
        claim_idx = lowest_set(claim);
        cnt_inc   = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;

        state_d       = state_q;
        cnt_d         = cnt_q;
        dn_valid_d    = dn_valid_q;
        dn_insn_d     = dn_insn_q;
        dn_rs1_d      = dn_rs1_q;
        dn_rs2_d      = dn_rs2_q;
        dn_rs3_d      = dn_rs3_q;
        up_wr_d       = up_wr_q;
        up_rd_d       = up_rd_q;
        up_wait_d     = up_wait_q;
        up_ready_d    = 1'b0;
        owner_d       = owner_q;
        err_timeout_d = err_timeout_q;
        err_multi_d   = err_multi_q;

        unique case (state_q)
            S_IDLE: begin
                if (up.up_valid) begin
                    dn_insn_d  = up.up_insn;
                    dn_rs1_d   = up.up_rs1;
                    dn_rs2_d   = up.up_rs2;
                    dn_rs3_d   = up.up_rs3;
                    dn_valid_d = '1;
                    cnt_d      = '0;
                    state_d    = S_PROBE;
                end
            end
            S_PROBE: begin
                cnt_d = cnt_inc;
                if (!up.up_valid) begin
                    dn_valid_d = '0;
                    up_wait_d  = 1'b0;
                    state_d    = S_IDLE;
                end else if (|claim) begin
                    if ((claim & (claim - 1'b1)) != '0) err_multi_d = 1'b1;
                    // a finished answer beats a request to stall, even from a higher index
                    if (|dn.dn_ready) begin
                        owner_d    = ready_idx;
                        up_wr_d    = dn.dn_wr[ready_idx];
                        up_rd_d    = dn.dn_rd[32*ready_idx +: 32];
                        up_ready_d = 1'b1;
                        dn_valid_d = '0;
                        state_d    = S_DONE;
                    end else begin
                        owner_d               = claim_idx;
                        dn_valid_d            = '0;
                        dn_valid_d[claim_idx] = 1'b1;
                        up_wait_d             = 1'b1;
                        cnt_d                 = '0;
                        state_d               = S_BUSY;
                    end
                end else if (cnt_inc == CNT_W'(PROBE_CYCLES)) begin
                    dn_valid_d = '0;
                    state_d    = S_DRAIN;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_inc;
                if (!up.up_valid) begin
                    dn_valid_d = '0;
                    up_wait_d  = 1'b0;
                    state_d    = S_IDLE;
                end else if (dn.dn_ready[owner_q]) begin
                    up_wr_d    = dn.dn_wr[owner_q];
                    up_rd_d    = dn.dn_rd[32*owner_q +: 32];
                    up_ready_d = 1'b1;
                    dn_valid_d = '0;
                    up_wait_d  = 1'b0;
                    state_d    = S_DONE;
                end else if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
                    err_timeout_d = 1'b1;
                    dn_valid_d    = '0;
                    up_wait_d     = 1'b0;
                    state_d       = S_DRAIN;
                end
            end
            S_DONE: begin
                up_wait_d = 1'b0;
                up_wr_d   = 1'b0;
                state_d   = S_DRAIN;
            end
            S_DRAIN: begin
                dn_valid_d = '0;
                if (!up.up_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign up.up_wr     = up_wr_q;
    assign up.up_rd     = up_rd_q;
    assign up.up_wait   = up_wait_q;
    assign up.up_ready  = up_ready_q;
    assign dn.dn_valid  = dn_valid_q;
    assign dn.dn_insn   = dn_insn_q;
    assign dn.dn_rs1    = dn_rs1_q;
    assign dn.dn_rs2    = dn_rs2_q;
    assign dn.dn_rs3    = dn_rs3_q;
    assign owner        = owner_q;
    assign err_timeout  = err_timeout_q;
    assign err_multi    = err_multi_q;

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Bench for pcpi_dispatch: each slave follows a wait/ready plan, and the expected
// per-cycle outputs come from an event-level model of who claims first and when.

module tb_pcpi_dispatch;

    localparam int NC = 2;
    localparam int PB = 8;
    localparam int BT = 16;
    localparam int NEVER = 1000;

    logic       clk = 1'b0;
    logic       resetn;
    logic [0:0] owner;
    logic       err_timeout;
    logic       err_multi;

    pcpi_up_if                    up_if ();
    pcpi_dn_if #(.NUM_COPROC(NC)) dn_if ();

    pcpi_dispatch #(
        .NUM_COPROC  (NC),
        .PROBE_CYCLES(PB),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .up         (up_if.slave),
        .dn         (dn_if.master),
        .owner      (owner),
        .err_timeout(err_timeout),
        .err_multi  (err_multi)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // slave plans: wait from p_ws until p_ra, ready pulse at p_ra (cycle offsets from dn_valid rise)
    int          p_ws [NC];
    int          p_ra [NC];
    logic [31:0] p_rd [NC];
    logic        p_wr [NC];

    int  m_owner;
    bit  m_multi;
    bit  m_to;

    int          o_ready_cnt, o_wait_cnt, o_dv_cnt;
    logic [31:0] o_rd;
    logic        o_wr;

    task automatic clear_slaves();
        dn_if.dn_wait  = '0;
        dn_if.dn_ready = '0;
        dn_if.dn_wr    = '0;
        dn_if.dn_rd    = '0;
    endtask

    task automatic silent_plan();
        for (int i = 0; i < NC; i++) begin
            p_ws[i] = NEVER;
            p_ra[i] = NEVER;
            p_rd[i] = $urandom;
            p_wr[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_txn(input string tag);
        int          c, win, nclaim, endb, k_end, mode;
        int          fc [NC];
        logic [31:0] insn, rs1, rs2, rs3;
        logic [NC-1:0] e_dv;
        logic        e_wait, e_ready, e_multi, e_to;
        int          e_owner;

        c = NEVER; win = -1; nclaim = 0; endb = 0; mode = 0;
        for (int i = 0; i < NC; i++) begin
            fc[i] = (p_ws[i] < p_ra[i]) ? p_ws[i] : p_ra[i];
            if (fc[i] < c) c = fc[i];
        end
        if (c < PB) begin
            for (int i = 0; i < NC; i++) if (fc[i] == c) nclaim++;
            for (int i = NC - 1; i >= 0; i--) if (p_ra[i] == c) win = i;
            if (win >= 0) mode = 1;
            else begin
                for (int i = NC - 1; i >= 0; i--) if (fc[i] == c) win = i;
                if (p_ra[win] - c <= BT) begin mode = 2; endb = p_ra[win]; end
                else begin mode = 3; endb = c + BT; end
            end
        end
        k_end = (mode == 0) ? PB + 2 : (mode == 1) ? c + 3 : endb + 3;

        insn = $urandom; rs1 = $urandom; rs2 = $urandom; rs3 = $urandom;
        o_ready_cnt = 0; o_wait_cnt = 0; o_dv_cnt = 0; o_rd = '0; o_wr = 1'b0;

        @(negedge clk);
        up_if.up_valid = 1'b1;
        up_if.up_insn  = insn;
        up_if.up_rs1   = rs1;
        up_if.up_rs2   = rs2;
        up_if.up_rs3   = rs3;

        for (int k = 0; k <= k_end; k++) begin
            @(negedge clk);
            if (mode == 0)      e_dv = (k < PB) ? '1 : '0;
            else if (mode == 1) e_dv = (k <= c) ? '1 : '0;
            else if (k <= c)    e_dv = '1;
            else begin
                e_dv = '0;
                if (k <= endb) e_dv[win] = 1'b1;
            end
            e_wait  = (mode >= 2) && (k >= c + 1) && (k <= endb);
            e_ready = (mode == 1 && k == c + 1) || (mode == 2 && k == endb + 1);
            e_owner = (mode != 0 && k >= c + 1) ? win : m_owner;
            e_multi = m_multi || (mode != 0 && nclaim > 1 && k >= c + 1);
            e_to    = m_to || (mode == 3 && k >= endb + 1);

            n_cmp += 6;
            if (dn_if.dn_valid !== e_dv) begin
                n_bad++; $display("FAIL %s dn_valid k=%0d got %b want %b", tag, k, dn_if.dn_valid, e_dv);
            end
            if (up_if.up_wait !== e_wait) begin
                n_bad++; $display("FAIL %s up_wait k=%0d got %b want %b", tag, k, up_if.up_wait, e_wait);
            end
            if (up_if.up_ready !== e_ready) begin
                n_bad++; $display("FAIL %s up_ready k=%0d got %b want %b", tag, k, up_if.up_ready, e_ready);
            end
            if (owner !== 1'(e_owner)) begin
                n_bad++; $display("FAIL %s owner k=%0d got %0d want %0d", tag, k, owner, e_owner);
            end
            if (err_multi !== e_multi) begin
                n_bad++; $display("FAIL %s err_multi k=%0d got %b want %b", tag, k, err_multi, e_multi);
            end
            if (err_timeout !== e_to) begin
                n_bad++; $display("FAIL %s err_timeout k=%0d got %b want %b", tag, k, err_timeout, e_to);
            end
            n_cmp++;
            if (e_ready) begin
                if (up_if.up_wr !== p_wr[win] || up_if.up_rd !== p_rd[win]) begin
                    n_bad++;
                    $display("FAIL %s result k=%0d got wr=%b rd=%h want wr=%b rd=%h",
                             tag, k, up_if.up_wr, up_if.up_rd, p_wr[win], p_rd[win]);
                end
            end else if (up_if.up_wr !== 1'b0) begin
                n_bad++; $display("FAIL %s up_wr k=%0d got %b want 0", tag, k, up_if.up_wr);
            end
            if (k == 0) begin
                n_cmp++;
                if (dn_if.dn_insn !== insn || dn_if.dn_rs1 !== rs1 ||
                    dn_if.dn_rs2 !== rs2 || dn_if.dn_rs3 !== rs3) begin
                    n_bad++;
                    $display("FAIL %s operands got %h %h %h %h want %h %h %h %h", tag,
                             dn_if.dn_insn, dn_if.dn_rs1, dn_if.dn_rs2, dn_if.dn_rs3, insn, rs1, rs2, rs3);
                end
            end
            if (up_if.up_ready === 1'b1) begin
                o_ready_cnt++; o_rd = up_if.up_rd; o_wr = up_if.up_wr;
            end
            if (up_if.up_wait === 1'b1) o_wait_cnt++;
            if (dn_if.dn_valid !== '0) o_dv_cnt++;

            for (int i = 0; i < NC; i++) begin
                dn_if.dn_wait[i]          = (p_ws[i] <= k) && (k < p_ra[i]);
                dn_if.dn_ready[i]         = (k == p_ra[i]);
                dn_if.dn_wr[i]            = p_wr[i];
                dn_if.dn_rd[32*i +: 32]   = p_rd[i];
            end
        end

        up_if.up_valid = 1'b0;
        clear_slaves();
        if (mode != 0) m_owner = win;
        if (mode != 0 && nclaim > 1) m_multi = 1'b1;
        if (mode == 3) m_to = 1'b1;

        @(negedge clk);
        n_cmp++;
        if (dn_if.dn_valid !== '0 || up_if.up_wait !== 1'b0 || up_if.up_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle got dv=%b wait=%b ready=%b want 0 0 0", tag,
                     dn_if.dn_valid, up_if.up_wait, up_if.up_ready);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        up_if.up_valid = 1'b0;
        up_if.up_insn = '0; up_if.up_rs1 = '0; up_if.up_rs2 = '0; up_if.up_rs3 = '0;
        clear_slaves();
        m_owner = 0; m_multi = 1'b0; m_to = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp += 3;
        if (up_if.up_wr !== 1'b0 || up_if.up_rd !== '0 || up_if.up_wait !== 1'b0 || up_if.up_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_up got wr=%b rd=%h wait=%b ready=%b want all 0",
                              up_if.up_wr, up_if.up_rd, up_if.up_wait, up_if.up_ready);
        end
        if (dn_if.dn_valid !== '0 || dn_if.dn_insn !== '0 || dn_if.dn_rs1 !== '0) begin
            n_bad++; $display("FAIL reset_dn got dv=%b insn=%h rs1=%h want 0",
                              dn_if.dn_valid, dn_if.dn_insn, dn_if.dn_rs1);
        end
        if (owner !== 1'b0 || err_multi !== 1'b0 || err_timeout !== 1'b0) begin
            n_bad++; $display("FAIL reset_status got owner=%0d multi=%b to=%b want 0",
                              owner, err_multi, err_timeout);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ready_direct();
        silent_plan();
        p_ws[1] = 2; p_ra[1] = 2; p_rd[1] = 32'hDEADBEEF; p_wr[1] = 1'b1;
        run_txn("ready_direct");
        n_cmp += 2;
        if (o_ready_cnt != 1 || o_rd !== 32'hDEADBEEF || o_wr !== 1'b1) begin
            n_bad++; $display("FAIL ready_direct_result got n=%0d rd=%h wr=%b want 1 deadbeef 1",
                              o_ready_cnt, o_rd, o_wr);
        end
        if (owner !== 1'b1) begin
            n_bad++; $display("FAIL ready_direct_owner got %0d want 1", owner);
        end
    endtask

    task automatic test_wait_then_ready();
        silent_plan();
        p_ws[0] = 1; p_ra[0] = 4; p_rd[0] = 32'h0000_1234; p_wr[0] = 1'b1;
        run_txn("wait_ready");
        n_cmp++;
        if (o_wait_cnt != 3 || o_ready_cnt != 1 || o_rd !== 32'h1234 || owner !== 1'b0) begin
            n_bad++; $display("FAIL wait_ready_summary got wait=%0d n=%0d rd=%h owner=%0d want 3 1 1234 0",
                              o_wait_cnt, o_ready_cnt, o_rd, owner);
        end
    endtask

    task automatic test_multi_claim();
        silent_plan();
        p_ws[0] = 2; p_ra[0] = 6; p_rd[0] = 32'hA5A5_0000;
        p_ws[1] = 2; p_ra[1] = 4; p_rd[1] = 32'h0000_5A5A;
        run_txn("multi_claim");
        n_cmp++;
        if (err_multi !== 1'b1 || owner !== 1'b0 || o_rd !== 32'hA5A5_0000 || o_ready_cnt != 1) begin
            n_bad++; $display("FAIL multi_claim_summary got multi=%b owner=%0d rd=%h n=%0d want 1 0 a5a50000 1",
                              err_multi, owner, o_rd, o_ready_cnt);
        end
    endtask

    task automatic test_no_claim();
        silent_plan();
        run_txn("no_claim");
        n_cmp++;
        if (o_dv_cnt != PB || o_wait_cnt != 0 || o_ready_cnt != 0) begin
            n_bad++; $display("FAIL no_claim_summary got dv_cycles=%0d wait=%0d ready=%0d want %0d 0 0",
                              o_dv_cnt, o_wait_cnt, o_ready_cnt, PB);
        end
    endtask

    task automatic test_timeout();
        silent_plan();
        p_ws[1] = 0;
        run_txn("timeout");
        n_cmp++;
        if (err_timeout !== 1'b1 || o_wait_cnt != BT || o_ready_cnt != 0) begin
            n_bad++; $display("FAIL timeout_summary got to=%b wait=%0d ready=%0d want 1 %0d 0",
                              err_timeout, o_wait_cnt, o_ready_cnt, BT);
        end
    endtask

    task automatic test_abort_and_reset();
        @(negedge clk);
        up_if.up_valid = 1'b1;
        up_if.up_insn  = 32'h0000_200B;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++;
                if (up_if.up_wait !== 1'b1 || dn_if.dn_valid !== 2'b01) begin
                    n_bad++; $display("FAIL abort_busy got wait=%b dv=%b want 1 01", up_if.up_wait, dn_if.dn_valid);
                end
            end
            if (k == 4) begin
                n_cmp++;
                if (dn_if.dn_valid !== '0 || up_if.up_wait !== 1'b0 || up_if.up_ready !== 1'b0) begin
                    n_bad++; $display("FAIL abort_quiet got dv=%b wait=%b ready=%b want 0 0 0",
                                      dn_if.dn_valid, up_if.up_wait, up_if.up_ready);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (up_if.up_ready !== 1'b0) begin
                    n_bad++; $display("FAIL abort_late_ready got %b want 0", up_if.up_ready);
                end
            end
            dn_if.dn_wait[0]  = (k <= 3);
            dn_if.dn_ready[0] = (k == 4);
            if (k == 3) up_if.up_valid = 1'b0;
        end
        clear_slaves();
        m_owner = 0;

        @(negedge clk);
        up_if.up_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dn_if.dn_valid !== 2'b11) begin
            n_bad++; $display("FAIL reset_probe_start got dv=%b want 11", dn_if.dn_valid);
        end
        @(negedge clk);
        resetn = 1'b0;
        up_if.up_valid = 1'b0;
        #1;
        n_cmp++;
        if (dn_if.dn_valid !== '0 || owner !== 1'b0 || err_multi !== 1'b0 || err_timeout !== 1'b0 ||
            up_if.up_wait !== 1'b0 || up_if.up_ready !== 1'b0 || up_if.up_rd !== '0) begin
            n_bad++; $display("FAIL reset_mid got dv=%b owner=%0d multi=%b to=%b wait=%b ready=%b rd=%h want 0",
                              dn_if.dn_valid, owner, err_multi, err_timeout,
                              up_if.up_wait, up_if.up_ready, up_if.up_rd);
        end
        m_owner = 0; m_multi = 1'b0; m_to = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        silent_plan();
        p_ws[1] = 3; p_ra[1] = 3; p_rd[1] = 32'hCAFE_F00D; p_wr[1] = 1'b1;
        run_txn("after_reset");
        n_cmp++;
        if (o_ready_cnt != 1 || o_rd !== 32'hCAFE_F00D) begin
            n_bad++; $display("FAIL after_reset_result got n=%0d rd=%h want 1 cafef00d", o_ready_cnt, o_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd_a;
        silent_plan();
        p_ws[0] = 0; p_ra[0] = 0; p_wr[0] = 1'b1;
        rd_a = p_rd[0];
        run_txn("b2b_first");
        n_cmp++;
        if (o_rd !== rd_a) begin
            n_bad++; $display("FAIL b2b_first_rd got %h want %h", o_rd, rd_a);
        end
        p_rd[0] = ~rd_a;
        run_txn("b2b_second");
        n_cmp++;
        if (o_rd !== ~rd_a || o_ready_cnt != 1) begin
            n_bad++; $display("FAIL b2b_second_rd got %h n=%0d want %h 1", o_rd, o_ready_cnt, ~rd_a);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            silent_plan();
            for (int i = 0; i < NC; i++) begin
                case ($urandom_range(0, 4))
                    0: ;
                    1: begin p_ws[i] = $urandom_range(0, 10); p_ra[i] = p_ws[i]; end
                    2: begin p_ws[i] = $urandom_range(0, 9);  p_ra[i] = p_ws[i] + $urandom_range(1, 20); end
                    3: begin p_ws[i] = $urandom_range(0, 9);  p_ra[i] = NEVER; end
                    default: begin p_ws[i] = $urandom_range(0, 3); p_ra[i] = p_ws[i] + $urandom_range(1, 4); end
                endcase
            end
            run_txn("random");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ready_direct();
        test_wait_then_ready();
        test_multi_claim();
        test_no_claim();
        test_timeout();
        test_abort_and_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
